// File: rtl/cl2_csr_reg_pkg.sv
// Machine-mode CSR register layouts and trap sequencer types shared by the
// CSR file, the trap controller and its interrupt synchroniser.
package cl2_csr_reg_pkg;

  typedef struct packed {
    logic       sd;
    logic [7:0] rsv_30_23;
    logic       tsr;
    logic       tw;
    logic       tvm;
    logic       mxr;
    logic       sum;
    logic       mprv;
    logic [1:0] xs;
    logic [1:0] fs;
    logic [1:0] mpp;
    logic [1:0] vs;
    logic       spp;
    logic       mpie;
    logic       ube;
    logic       spie;
    logic       rsv_4;
    logic       mie;
    logic       rsv_2;
    logic       sie;
    logic       rsv_0;
  } cl2_csr_mstatus_reg_t;

  typedef struct packed {
    logic [17:0] rsv_31_14;
    logic        lcofie;
    logic        rsv_12;
    logic        meie;
    logic [2:0]  rsv_10_8;
    logic        mtie;
    logic [2:0]  rsv_6_4;
    logic        msie;
    logic [2:0]  rsv_2_0;
  } cl2_csr_mie_reg_t;

  typedef struct packed {
    logic [17:0] rsv_31_14;
    logic        lcofip;
    logic        rsv_12;
    logic        meip;
    logic [2:0]  rsv_10_8;
    logic        mtip;
    logic [2:0]  rsv_6_4;
    logic        msip;
    logic [2:0]  rsv_2_0;
  } cl2_csr_mip_reg_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    UPDATE   = 2'd2,
    REDIRECT = 2'd3
  } cl2_trap_state_e;

  localparam logic [3:0] IRQ_MSI  = 4'd3;
  localparam logic [3:0] IRQ_MTI  = 4'd7;
  localparam logic [3:0] IRQ_MEI  = 4'd11;
  localparam logic [3:0] IRQ_LCOF = 4'd13;
  localparam logic [1:0] PRIV_M   = 2'b11;

endpackage

// File: rtl/cl2_trap_ctrl_irq_sync.sv
// Synchronises the raw machine interrupt lines into an mip image and picks
// the highest-priority enabled pending interrupt.
module cl2_irq_sync
  import cl2_csr_reg_pkg::*;
#(
  parameter int SyncStages = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             irq_meip_i,
  input  logic             irq_mtip_i,
  input  logic             irq_msip_i,
  input  logic             irq_lcofip_i,
  input  logic [3:0]       irq_en_i,      // {lcofie, meie, mtie, msie}
  input  logic             global_mie_i,
  output cl2_csr_mip_reg_t mip_o,
  output logic             irq_take_o,
  output logic [3:0]       irq_code_o
);

  logic [3:0] raw_s;
  logic [3:0] synced_s;
  logic [3:0] pend_en_s;

  assign raw_s = {irq_lcofip_i, irq_meip_i, irq_mtip_i, irq_msip_i};

  if (SyncStages == 0) begin : g_nosync
    assign synced_s = raw_s;
  end else begin : g_sync
    logic [SyncStages-1:0][3:0] sync_r;

    // Shift chain from raw lines into the mip image
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sync_r <= '0;
      end else begin
        sync_r[0] <= raw_s;
        for (int i = 1; i < SyncStages; i++) begin
          sync_r[i] <= sync_r[i-1];
        end
      end
    end

    assign synced_s = sync_r[SyncStages-1];
  end

  assign pend_en_s = synced_s & irq_en_i;

  // Build mip image and apply fixed MEI > MSI > MTI > LCOF priority
  always_comb begin
    mip_o        = '0;
    mip_o.msip   = synced_s[0];
    mip_o.mtip   = synced_s[1];
    mip_o.meip   = synced_s[2];
    mip_o.lcofip = synced_s[3];
    irq_take_o   = global_mie_i & (|pend_en_s);
    if (pend_en_s[2]) begin
      irq_code_o = IRQ_MEI;
    end else if (pend_en_s[0]) begin
      irq_code_o = IRQ_MSI;
    end else if (pend_en_s[1]) begin
      irq_code_o = IRQ_MTI;
    end else begin
      irq_code_o = IRQ_LCOF;
    end
  end

endmodule

// File: rtl/cl2_trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, mret and interrupts,
// then runs flush -> CSR update -> fetch redirect.
module cl2_trap_ctrl
  import cl2_csr_reg_pkg::*;
#(
  parameter bit VectoredEn    = 1'b1,
  parameter int IrqSyncStages = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  cl2_csr_mstatus_reg_t mstatus_i,
  input  cl2_csr_mie_reg_t     mie_i,
  input  logic [31:0]          mtvec_i,
  input  logic [31:0]          mepc_i,
  input  logic                 irq_meip_i,
  input  logic                 irq_mtip_i,
  input  logic                 irq_msip_i,
  input  logic                 irq_lcofip_i,
  input  logic                 exc_valid_i,
  input  logic [4:0]           exc_cause_i,
  input  logic [31:0]          exc_pc_i,
  input  logic [31:0]          exc_tval_i,
  input  logic                 mret_valid_i,
  input  logic [31:0]          next_pc_i,
  input  logic                 pipe_empty_i,
  output logic                 busy_o,
  output logic                 flush_o,
  output cl2_csr_mip_reg_t     mip_o,
  output logic                 csr_we_o,
  output cl2_csr_mstatus_reg_t mstatus_wdata_o,
  output logic [31:0]          mepc_wdata_o,
  output logic [31:0]          mcause_wdata_o,
  output logic [31:0]          mtval_wdata_o,
  output logic                 mepc_we_o,
  output logic                 mcause_we_o,
  output logic                 mtval_we_o,
  output logic                 redirect_valid_o,
  output logic [31:0]          redirect_pc_o,
  input  logic                 redirect_ready_i
);

  cl2_trap_state_e      state_r;
  logic                 is_mret_r;
  logic                 is_irq_r;
  logic [31:0]          cause_r;
  logic [31:0]          epc_r;
  logic [31:0]          tval_r;
  logic                 irq_take_s;
  logic [3:0]           irq_code_s;
  logic [31:0]          base_s;
  logic [31:0]          target_s;
  cl2_csr_mstatus_reg_t mstatus_next_s;

  cl2_irq_sync #(.SyncStages(IrqSyncStages)) u_irq_sync (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .irq_meip_i   (irq_meip_i),
    .irq_mtip_i   (irq_mtip_i),
    .irq_msip_i   (irq_msip_i),
    .irq_lcofip_i (irq_lcofip_i),
    .irq_en_i     ({mie_i.lcofie, mie_i.meie, mie_i.mtie, mie_i.msie}),
    .global_mie_i (mstatus_i.mie),
    .mip_o        (mip_o),
    .irq_take_o   (irq_take_s),
    .irq_code_o   (irq_code_s)
  );

  assign base_s = {mtvec_i[31:2], 2'b00};

  // Next mstatus image and redirect target for the latched event
  always_comb begin
    mstatus_next_s     = mstatus_i;
    mstatus_next_s.mpp = PRIV_M;
    if (is_mret_r) begin
      mstatus_next_s.mie  = mstatus_i.mpie;
      mstatus_next_s.mpie = 1'b1;
    end else begin
      mstatus_next_s.mpie = mstatus_i.mie;
      mstatus_next_s.mie  = 1'b0;
    end
    if (is_mret_r) begin
      target_s = mepc_i;
    end else if (VectoredEn && (mtvec_i[1:0] == 2'b01) && is_irq_r) begin
      target_s = base_s + {26'd0, cause_r[3:0], 2'b00};
    end else begin
      target_s = base_s;
    end
  end

  // Sequencer with all outputs registered alongside the state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r          <= IDLE;
      is_mret_r        <= 1'b0;
      is_irq_r         <= 1'b0;
      cause_r          <= 32'd0;
      epc_r            <= 32'd0;
      tval_r           <= 32'd0;
      busy_o           <= 1'b0;
      flush_o          <= 1'b0;
      csr_we_o         <= 1'b0;
      mstatus_wdata_o  <= '0;
      mepc_wdata_o     <= 32'd0;
      mcause_wdata_o   <= 32'd0;
      mtval_wdata_o    <= 32'd0;
      mepc_we_o        <= 1'b0;
      mcause_we_o      <= 1'b0;
      mtval_we_o       <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (exc_valid_i || mret_valid_i || irq_take_s) begin
            state_r <= FLUSH;
            busy_o  <= 1'b1;
            flush_o <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
          if (exc_valid_i) begin
            is_mret_r <= 1'b0;
            is_irq_r  <= 1'b0;
            cause_r   <= {27'd0, exc_cause_i};
            epc_r     <= exc_pc_i;
            tval_r    <= exc_tval_i;
          end else if (mret_valid_i) begin
            is_mret_r <= 1'b1;
            is_irq_r  <= 1'b0;
          end else if (irq_take_s) begin
            is_mret_r <= 1'b0;
            is_irq_r  <= 1'b1;
            cause_r   <= {1'b1, 27'd0, irq_code_s};
            epc_r     <= next_pc_i;
            tval_r    <= 32'd0;
          end else begin
            is_mret_r <= is_mret_r;
          end
        end
        FLUSH: begin
          if (pipe_empty_i) begin
            state_r         <= UPDATE;
            flush_o         <= 1'b0;
            csr_we_o        <= 1'b1;
            mstatus_wdata_o <= mstatus_next_s;
            mepc_wdata_o    <= epc_r & 32'hFFFF_FFFC;
            mcause_wdata_o  <= cause_r;
            mtval_wdata_o   <= tval_r;
            mepc_we_o       <= ~is_mret_r;
            mcause_we_o     <= ~is_mret_r;
            mtval_we_o      <= ~is_mret_r;
          end else begin
            flush_o <= 1'b1;
          end
        end
        UPDATE: begin
          state_r          <= REDIRECT;
          csr_we_o         <= 1'b0;
          mepc_we_o        <= 1'b0;
          mcause_we_o      <= 1'b0;
          mtval_we_o       <= 1'b0;
          redirect_valid_o <= 1'b1;
          redirect_pc_o    <= target_s;
        end
        REDIRECT: begin
          if (redirect_ready_i) begin
            state_r          <= IDLE;
            redirect_valid_o <= 1'b0;
            busy_o           <= 1'b0;
          end else begin
            redirect_valid_o <= 1'b1;
          end
        end
        default: begin
          state_r          <= IDLE;
          busy_o           <= 1'b0;
          flush_o          <= 1'b0;
          csr_we_o         <= 1'b0;
          redirect_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cl2_trap_ctrl.sv
// Directed self-checking bench for cl2_trap_ctrl with hand-computed vectors.
module tb_cl2_trap_ctrl;
  import cl2_csr_reg_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_i;
  cl2_csr_mstatus_reg_t mstatus_i;
  cl2_csr_mie_reg_t     mie_i;
  logic [31:0]          mtvec_i, mepc_i;
  logic                 irq_meip_i, irq_mtip_i, irq_msip_i, irq_lcofip_i;
  logic                 exc_valid_i;
  logic [4:0]           exc_cause_i;
  logic [31:0]          exc_pc_i, exc_tval_i;
  logic                 mret_valid_i;
  logic [31:0]          next_pc_i;
  logic                 pipe_empty_i;
  logic                 busy_o, flush_o, csr_we_o;
  cl2_csr_mip_reg_t     mip_o;
  cl2_csr_mstatus_reg_t mstatus_wdata_o;
  logic [31:0]          mepc_wdata_o, mcause_wdata_o, mtval_wdata_o;
  logic                 mepc_we_o, mcause_we_o, mtval_we_o;
  logic                 redirect_valid_o;
  logic [31:0]          redirect_pc_o;
  logic                 redirect_ready_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cl2_trap_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .mstatus_i(mstatus_i), .mie_i(mie_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .irq_meip_i(irq_meip_i), .irq_mtip_i(irq_mtip_i), .irq_msip_i(irq_msip_i),
    .irq_lcofip_i(irq_lcofip_i), .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
    .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i), .mret_valid_i(mret_valid_i),
    .next_pc_i(next_pc_i), .pipe_empty_i(pipe_empty_i), .busy_o(busy_o),
    .flush_o(flush_o), .mip_o(mip_o), .csr_we_o(csr_we_o),
    .mstatus_wdata_o(mstatus_wdata_o), .mepc_wdata_o(mepc_wdata_o),
    .mcause_wdata_o(mcause_wdata_o), .mtval_wdata_o(mtval_wdata_o),
    .mepc_we_o(mepc_we_o), .mcause_we_o(mcause_we_o), .mtval_we_o(mtval_we_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .redirect_ready_i(redirect_ready_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; mstatus_i = '0; mie_i = '0; mtvec_i = 32'd0; mepc_i = 32'd0;
    irq_meip_i = 1'b0; irq_mtip_i = 1'b0; irq_msip_i = 1'b0; irq_lcofip_i = 1'b0;
    exc_valid_i = 1'b0; exc_cause_i = 5'd0; exc_pc_i = 32'd0; exc_tval_i = 32'd0;
    mret_valid_i = 1'b0; next_pc_i = 32'd0; pipe_empty_i = 1'b1; redirect_ready_i = 1'b1;
    tick(); tick();
    total++;
    if ({busy_o, flush_o, csr_we_o, redirect_valid_o, mepc_we_o, mcause_we_o, mtval_we_o} !== 7'd0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0", {busy_o, flush_o, csr_we_o, redirect_valid_o});
    end
    total++;
    if (mip_o !== 32'd0 || redirect_pc_o !== 32'd0 || mcause_wdata_o !== 32'd0) begin
      bad++; $display("FAIL reset_data: mip=%h pc=%h cause=%h want 0", mip_o, redirect_pc_o, mcause_wdata_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_exception();
    mtvec_i = 32'h8000_0000; mstatus_i = '0; mstatus_i.mie = 1'b1; mstatus_i.fs = 2'b10;
    exc_valid_i = 1'b1; exc_cause_i = 5'd2; exc_pc_i = 32'h8000_0104; exc_tval_i = 32'hDEAD_BEEF;
    pipe_empty_i = 1'b1; redirect_ready_i = 1'b1;
    tick();
    exc_valid_i = 1'b0;
    total++;
    if (busy_o !== 1'b1 || flush_o !== 1'b1 || csr_we_o !== 1'b0) begin
      bad++; $display("FAIL exc_cycle1: busy=%b flush=%b we=%b want 1 1 0", busy_o, flush_o, csr_we_o);
    end
    tick();
    total++;
    if (csr_we_o !== 1'b1 || {mepc_we_o, mcause_we_o, mtval_we_o} !== 3'b111 || flush_o !== 1'b0) begin
      bad++; $display("FAIL exc_we: we=%b sub=%b%b%b flush=%b want 1 111 0", csr_we_o, mepc_we_o, mcause_we_o, mtval_we_o, flush_o);
    end
    total++;
    if (mepc_wdata_o !== 32'h8000_0104 || mcause_wdata_o !== 32'h2 || mtval_wdata_o !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL exc_data: mepc=%h mcause=%h mtval=%h want 80000104 2 deadbeef", mepc_wdata_o, mcause_wdata_o, mtval_wdata_o);
    end
    total++;
    if (mstatus_wdata_o.mie !== 1'b0 || mstatus_wdata_o.mpie !== 1'b1 || mstatus_wdata_o.mpp !== 2'b11 || mstatus_wdata_o.fs !== 2'b10) begin
      bad++; $display("FAIL exc_mstatus: got %h want mie0 mpie1 mpp11 fs10", mstatus_wdata_o);
    end
    tick();
    total++;
    if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h8000_0000 || csr_we_o !== 1'b0) begin
      bad++; $display("FAIL exc_redirect: v=%b pc=%h we=%b want 1 80000000 0", redirect_valid_o, redirect_pc_o, csr_we_o);
    end
    tick();
    total++;
    if (busy_o !== 1'b0 || redirect_valid_o !== 1'b0) begin
      bad++; $display("FAIL exc_idle: busy=%b v=%b want 0 0", busy_o, redirect_valid_o);
    end
  endtask

  // Interrupt trap with line dropped once latched; checks data and redirect
  task automatic run_irq(input string name, input logic [31:0] exp_cause, input logic [31:0] exp_pc);
    int n;
    n = 0;
    while (busy_o !== 1'b1 && n < 10) begin tick(); n++; end
    irq_meip_i = 1'b0; irq_mtip_i = 1'b0; irq_msip_i = 1'b0;
    n = 0;
    while (csr_we_o !== 1'b1 && n < 10) begin tick(); n++; end
    total++;
    if (csr_we_o !== 1'b1 || mcause_wdata_o !== exp_cause || mepc_wdata_o !== 32'h200 || mtval_wdata_o !== 32'd0) begin
      bad++; $display("FAIL %s_data: we=%b mcause=%h mepc=%h mtval=%h want 1 %h 200 0", name, csr_we_o, mcause_wdata_o, mepc_wdata_o, mtval_wdata_o, exp_cause);
    end
    tick();
    total++;
    if (redirect_valid_o !== 1'b1 || redirect_pc_o !== exp_pc) begin
      bad++; $display("FAIL %s_redirect: v=%b pc=%h want 1 %h", name, redirect_valid_o, redirect_pc_o, exp_pc);
    end
    tick(); tick();
    total++;
    if (busy_o !== 1'b0) begin
      bad++; $display("FAIL %s_retrap: busy=%b want 0", name, busy_o);
    end
  endtask

  task automatic test_vectored_irq();
    mtvec_i = 32'h8000_0001; mstatus_i = '0; mstatus_i.mie = 1'b1;
    mie_i = '0; mie_i.mtie = 1'b1; next_pc_i = 32'h200; irq_mtip_i = 1'b1;
    run_irq("vec_mti", 32'h8000_0007, 32'h8000_001C);
  endtask

  task automatic test_priority();
    mie_i = '0; mie_i.meie = 1'b1; mie_i.msie = 1'b1; mie_i.mtie = 1'b1;
    irq_meip_i = 1'b1; irq_msip_i = 1'b1; irq_mtip_i = 1'b1;
    run_irq("prio_mei", 32'h8000_000B, 32'h8000_002C);
  endtask

  task automatic test_mask_and_exc_priority();
    int n;
    mstatus_i.mie = 1'b0; mie_i = '0; mie_i.meie = 1'b1; irq_meip_i = 1'b1;
    tick();
    total++;
    if (mip_o.meip !== 1'b1 || mip_o.mtip !== 1'b0) begin
      bad++; $display("FAIL mip_image: got %h want 00000800", mip_o);
    end
    tick(); tick();
    total++;
    if (busy_o !== 1'b0) begin
      bad++; $display("FAIL masked_irq: busy=%b want 0", busy_o);
    end
    mstatus_i.mie = 1'b1; exc_valid_i = 1'b1; exc_cause_i = 5'd5; exc_pc_i = 32'h300;
    tick();
    exc_valid_i = 1'b0; irq_meip_i = 1'b0;
    n = 0;
    while (csr_we_o !== 1'b1 && n < 10) begin tick(); n++; end
    total++;
    if (csr_we_o !== 1'b1 || mcause_wdata_o !== 32'h5 || mepc_wdata_o !== 32'h300) begin
      bad++; $display("FAIL exc_over_irq: we=%b mcause=%h mepc=%h want 1 5 300", csr_we_o, mcause_wdata_o, mepc_wdata_o);
    end
    tick();
    total++;
    if (redirect_pc_o !== 32'h8000_0000) begin
      bad++; $display("FAIL exc_not_vectored: pc=%h want 80000000", redirect_pc_o);
    end
    tick(); tick();
  endtask

  task automatic test_mret();
    mie_i = '0; mstatus_i = '0; mstatus_i.mpie = 1'b1; mepc_i = 32'h1234;
    mret_valid_i = 1'b1;
    tick();
    mret_valid_i = 1'b0;
    tick();
    total++;
    if (csr_we_o !== 1'b1 || {mepc_we_o, mcause_we_o, mtval_we_o} !== 3'b000) begin
      bad++; $display("FAIL mret_we: we=%b sub=%b%b%b want 1 000", csr_we_o, mepc_we_o, mcause_we_o, mtval_we_o);
    end
    total++;
    if (mstatus_wdata_o.mie !== 1'b1 || mstatus_wdata_o.mpie !== 1'b1 || mstatus_wdata_o.mpp !== 2'b11) begin
      bad++; $display("FAIL mret_mstatus: got %h want mie1 mpie1 mpp11", mstatus_wdata_o);
    end
    tick();
    total++;
    if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h1234) begin
      bad++; $display("FAIL mret_redirect: v=%b pc=%h want 1 1234", redirect_valid_o, redirect_pc_o);
    end
    tick();
  endtask

  task automatic test_back_to_back_backpressure();
    mstatus_i = '0; mstatus_i.mie = 1'b1; mtvec_i = 32'h0000_4000;
    exc_valid_i = 1'b1; exc_cause_i = 5'd7; exc_pc_i = 32'h40; pipe_empty_i = 1'b0; redirect_ready_i = 1'b0;
    tick();
    exc_valid_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (flush_o !== 1'b1 || csr_we_o !== 1'b0) begin
        bad++; $display("FAIL flush_hold%0d: flush=%b we=%b want 1 0", i, flush_o, csr_we_o);
      end
      if (i == 4) pipe_empty_i = 1'b1;
      tick();
    end
    total++;
    if (csr_we_o !== 1'b1 || flush_o !== 1'b0) begin
      bad++; $display("FAIL flush_update: we=%b flush=%b want 1 0", csr_we_o, flush_o);
    end
    tick();
    for (int j = 0; j < 3; j++) begin
      total++;
      if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h0000_4000 || busy_o !== 1'b1) begin
        bad++; $display("FAIL bp_hold%0d: v=%b pc=%h busy=%b want 1 00004000 1", j, redirect_valid_o, redirect_pc_o, busy_o);
      end
      tick();
    end
    redirect_ready_i = 1'b1;
    total++;
    if (redirect_valid_o !== 1'b1) begin
      bad++; $display("FAIL bp_handshake: v=%b want 1", redirect_valid_o);
    end
    tick();
    total++;
    if (busy_o !== 1'b0 || redirect_valid_o !== 1'b0) begin
      bad++; $display("FAIL bp_idle: busy=%b v=%b want 0 0", busy_o, redirect_valid_o);
    end
  endtask

  task automatic test_reset_mid_flush();
    int seen;
    exc_valid_i = 1'b1; exc_cause_i = 5'd4; pipe_empty_i = 1'b0;
    tick();
    exc_valid_i = 1'b0; rst_i = 1'b1;
    tick();
    rst_i = 1'b0; pipe_empty_i = 1'b1;
    total++;
    if (busy_o !== 1'b0 || flush_o !== 1'b0) begin
      bad++; $display("FAIL rst_mid: busy=%b flush=%b want 0 0", busy_o, flush_o);
    end
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (csr_we_o !== 1'b0 || redirect_valid_o !== 1'b0) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL rst_no_write: active_cycles=%0d want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_vectored_irq();
    test_priority();
    test_mask_and_exc_priority();
    test_mret();
    test_back_to_back_backpressure();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
